// File: rtl/sat_correlator.sv
// GPS C/A despreader: correlates a signed sample stream against an internal Gold replica
// over one code epoch and hands the sum out through a valid/ready dump port.
// Optional build macro SAT_CORR_SATURATE_EN makes the accumulator saturate instead of wrapping.
module sat_correlator #(
  parameter int IN_W          = 12,
  parameter int ACC_W         = 24,
  parameter int SAMP_PER_CHIP = 4,
  parameter int CODE_LEN      = 1023
) (
  input  logic                    clk,
  input  logic                    RESET,
  input  logic                    start,
  input  logic                    stop,
  input  logic [3:0]              tap_a,
  input  logic [3:0]              tap_b,
  input  logic signed [IN_W-1:0]  sample_in,
  input  logic                    sample_valid,
  output logic signed [ACC_W-1:0] dump_data,
  output logic                    dump_valid,
  input  logic                    dump_ready,
  output logic                    busy,
  output logic                    overrun
);

  localparam int SW = $clog2(SAMP_PER_CHIP + 1);
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMP_PER_CHIP - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(CODE_LEN - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [3:0]              ta;
  logic [3:0]              tb;
  logic [10:1]             g1;
  logic [10:1]             g2;
  logic [SW-1:0]           sample_cnt;
  logic [CW-1:0]           chip_cnt;
  logic signed [ACC_W-1:0] acc;

  logic                    chip;
  logic                    adv;
  logic                    chip_wrap;
  logic                    epoch_end;
  logic signed [ACC_W-1:0] sext;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] acc_next;
`ifdef SAT_CORR_SATURATE_EN
  logic [ACC_W:0]          sum_wide;
`endif

  // Out-of-range tap selections fall back to the last G2 stage.
  function automatic logic [3:0] eff_tap(input logic [3:0] t);
    return (t == 4'd0 || t > 4'd10) ? 4'd10 : t;
  endfunction

  always_comb begin
    chip      = g1[10] ^ g2[ta] ^ g2[tb];
    adv       = (state == RUN) && sample_valid && !stop && !start;
    chip_wrap = adv && (sample_cnt == SAMP_LAST);
    epoch_end = chip_wrap && (chip_cnt == CHIP_LAST);
    // Extend before negating so the most negative input maps to an exact positive term.
    sext      = ACC_W'(sample_in);
    term      = chip ? -sext : sext;
`ifdef SAT_CORR_SATURATE_EN
    sum_wide  = {acc[ACC_W-1], acc} + {term[ACC_W-1], term};
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
      acc_next = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next = sum_wide[ACC_W-1:0];
`else
    acc_next  = acc + term;
`endif
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      busy       <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      overrun    <= 1'b0;
      acc        <= '0;
      sample_cnt <= '0;
      chip_cnt   <= '0;
      g1         <= '1;
      g2         <= '1;
      ta         <= 4'd2;
      tb         <= 4'd6;
    end else begin
      if (dump_valid && dump_ready)
        dump_valid <= 1'b0;
      // A finished epoch loads only into an empty or simultaneously drained output.
      if (epoch_end) begin
        if (!dump_valid || dump_ready) begin
          dump_data  <= acc_next;
          dump_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        state      <= RUN;
        busy       <= 1'b1;
        ta         <= eff_tap(tap_a);
        tb         <= eff_tap(tap_b);
        g1         <= '1;
        g2         <= '1;
        acc        <= '0;
        sample_cnt <= '0;
        chip_cnt   <= '0;
        overrun    <= 1'b0;
      end else if (adv) begin
        if (epoch_end) begin
          acc        <= '0;
          sample_cnt <= '0;
          chip_cnt   <= '0;
          g1         <= '1;
          g2         <= '1;
        end else begin
          acc <= acc_next;
          if (chip_wrap) begin
            sample_cnt <= '0;
            chip_cnt   <= chip_cnt + 1'b1;
            g1         <= {g1[9:1], g1[3] ^ g1[10]};
            g2         <= {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
